// File: rtl/aes_pkg.sv
// Shared AES definitions: state sizes, engine FSM states and GF(2^8) helpers
// used by the combined S-box and the optional InvShiftRows on capture.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} aes_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // Byte (row r, col c) moves to (r, (c+r) mod 4); byte i = 4*col + row
  function automatic logic [AES_STATE_W-1:0] inv_shift_rows(input logic [AES_STATE_W-1:0] s);
    logic [AES_STATE_W-1:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[AES_STATE_W-1-8*(4*((c+r)%4)+r) -: 8] = s[AES_STATE_W-1-8*(4*c+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sub_lane.sv
// Combined AES S-box (encrypt selects forward/inverse) and a lane of LANES
// inverse S-boxes mapping a LANES-byte slice in place.
module aes_sbox
  import aes_pkg::*;
(
  input  logic       encrypt,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] pre;
  logic [7:0] inv;

  assign pre  = encrypt ? din : inv_affine(din);
  assign inv  = gf_inv(pre);
  assign dout = encrypt ? fwd_affine(inv) : inv;

endmodule

module aes_inv_sub_lane #(
  parameter int LANES = 4
) (
  input  logic [8*LANES-1:0] din,
  output logic [8*LANES-1:0] dout
);

  for (genvar j = 0; j < LANES; j++) begin : g_sbox
    aes_sbox u_sbox (
      .encrypt (1'b0),
      .din     (din[8*j +: 8]),
      .dout    (dout[8*j +: 8])
    );
  end

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Sequential InvSubBytes engine: LANES bytes per cycle over valid/ready.
// Define AES_INV_SHIFTROWS_EN to apply InvShiftRows while capturing the state.
module aes_inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  localparam int STEPS = AES_BYTES / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int SW    = 8 * LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  aes_state_e             state, state_nx;
  logic [CW-1:0]          cnt;
  logic [AES_STATE_W-1:0] work;
  logic [AES_STATE_W-1:0] captured;
  logic [SW-1:0]          lane_in, lane_out;
  logic [6:0]             lane_top;
  logic                   last_step;

`ifdef AES_INV_SHIFTROWS_EN
  assign captured = inv_shift_rows(in_state);
`else
  assign captured = in_state;
`endif

  assign last_step = (cnt == CW'(STEPS - 1));

  // Step cnt covers bytes cnt*LANES.. upward, i.e. a slice counted down from the MSB
  always_comb begin
    lane_top = 7'(AES_STATE_W - 1 - SW * int'(cnt));
    lane_in  = work[lane_top -: SW];
  end

  aes_inv_sub_lane #(.LANES(LANES)) u_lane (
    .din  (lane_in),
    .dout (lane_out)
  );

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign out_state = (state == DONE) ? work : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= captured;
            cnt  <= '0;
          end
        end
        BUSY: begin
          work[lane_top -: SW] <= lane_out;
          if (!last_step) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
